// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker: exhaustive (s,t) sweep of a Skolem block for "exists x: (x >>u s) >=s t".
// Define STOP_ON_FAIL_EN to end the sweep at the first failing pair.
module skolem_sweep_checker #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   sk_s,
   output logic [W-1:0]   sk_t,
   input  logic [W-1:0]   sk_x,
   output logic [2*W:0]   pass_cnt,
   output logic [2*W:0]   fail_cnt,
   output logic           first_fail_vld,
   output logic [W-1:0]   first_fail_s,
   output logic [W-1:0]   first_fail_t
);
   typedef enum logic [2:0] {IDLE, APPLY, EVAL, SEARCH, NEXT, DONE} state_t;

   state_t           state_q, state_d;
   logic [2*W-1:0]   idx_q, idx_d;
   logic [W-1:0]     xs_q, xs_d;
   logic [2*W:0]     pass_q, pass_d, fail_q, fail_d;
   logic             vld_q, vld_d;
   logic [W-1:0]     ffs_q, ffs_d, fft_q, fft_d;

   // A logical shift by s >= W already yields zero.
   function automatic logic pred(input logic [W-1:0] x, input logic [W-1:0] s, input logic [W-1:0] t);
      logic [W-1:0] sh;
      sh = x >> s;
      return $signed(sh) >= $signed(t);
   endfunction

   assign sk_s           = idx_q[2*W-1:W];
   assign sk_t           = idx_q[W-1:0];
   assign busy           = state_q inside {APPLY, EVAL, SEARCH, NEXT};
   assign done           = state_q == DONE;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign first_fail_vld = vld_q;
   assign first_fail_s   = ffs_q;
   assign first_fail_t   = fft_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      xs_d    = xs_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      vld_d   = vld_q;
      ffs_d   = ffs_q;
      fft_d   = fft_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = APPLY;
            idx_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            vld_d   = 1'b0;
            ffs_d   = '0;
            fft_d   = '0;
         end
         APPLY: state_d = EVAL;
         EVAL: begin
            state_d = pred(sk_x, sk_s, sk_t) ? NEXT : SEARCH;
            pass_d  = pred(sk_x, sk_s, sk_t) ? pass_q + 1'b1 : pass_q;
            xs_d    = '0;
         end
         SEARCH: if (pred(xs_q, sk_s, sk_t)) begin
            fail_d = fail_q + 1'b1;
            vld_d  = 1'b1;
            ffs_d  = vld_q ? ffs_q : sk_s;
            fft_d  = vld_q ? fft_q : sk_t;
`ifdef STOP_ON_FAIL_EN
            state_d = DONE;
`else
            state_d = NEXT;
`endif
         end else if (&xs_q) begin
            pass_d  = pass_q + 1'b1;
            state_d = NEXT;
         end else begin
            xs_d = xs_q + 1'b1;
         end
         NEXT: begin
            state_d = &idx_q ? DONE : APPLY;
            idx_d   = &idx_q ? idx_q : idx_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         xs_q    <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         vld_q   <= 1'b0;
         ffs_q   <= '0;
         fft_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         xs_q    <= xs_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         vld_q   <= vld_d;
         ffs_q   <= ffs_d;
         fft_q   <= fft_d;
      end
   end
endmodule
